// File: rtl/data_link_tx.sv
// data_link_tx: round-robin framer for four FIFOs with sequence numbers, parity, replay buffer and ACK/NAK handling
module data_link_tx #(
  parameter int DATA_W = 10,
  parameter int SEQ_W = 8,
  parameter int REPLAY_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      empty0,
  input  logic                      empty1,
  input  logic                      empty2,
  input  logic                      empty3,
  input  logic [DATA_W-1:0]         data_in0,
  input  logic [DATA_W-1:0]         data_in1,
  input  logic [DATA_W-1:0]         data_in2,
  input  logic [DATA_W-1:0]         data_in3,
  output logic                      pop0,
  output logic                      pop1,
  output logic                      pop2,
  output logic                      pop3,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [SEQ_W+DATA_W+2:0]   tx_data,
  input  logic                      ack_valid,
  input  logic                      ack_nak,
  input  logic [SEQ_W-1:0]          ack_seq,
  output logic                      replay_full,
  output logic [1:0]                state
);
  localparam int FW = SEQ_W + DATA_W + 3;
  localparam int AW = $clog2(REPLAY_DEPTH);
  localparam int OW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, REPLAY} state_t;
  state_t state_q, state_d;
  logic [3:0] pop_q, pop_d;
  logic tx_valid_q, tx_valid_d, nak_pending_q, nak_pending_d, restart_q, restart_d;
  logic [FW-1:0] tx_data_q, tx_data_d;
  logic [SEQ_W-1:0] next_seq_q, next_seq_d, oseq_q, oseq_d, rseq_q, rseq_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [1:0] rr_q, rr_d, grant_q, grant_d;
  logic [FW-1:0] rbuf_q [REPLAY_DEPTH];
  logic [3:0] empty_v;
  logic [DATA_W-1:0] din [4];
  logic [1:0] c1, c2, c3, gnt;
  logic hs, in_win, wr, nak_now, restart, done;
  logic [SEQ_W-1:0] off, n, oseq_new, rdif, nxt, ndif;
  logic [OW-1:0] out_new;
  logic [DATA_W-1:0] fdat;
  logic [FW-1:0] frame;
  assign empty_v = {empty3, empty2, empty1, empty0};
  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;
  assign c1 = rr_q + 2'd1;
  assign c2 = rr_q + 2'd2;
  assign c3 = rr_q + 2'd3;
  assign gnt = !empty_v[c1] ? c1 : !empty_v[c2] ? c2 : !empty_v[c3] ? c3 : rr_q;
  assign hs = tx_valid_q && tx_ready;
  assign off = ack_seq - oseq_q;
  assign in_win = ack_valid && off < SEQ_W'(outstanding_q);
  assign n = in_win ? off + 1'b1 : '0;
  assign wr = state_q == FETCH && pop_q == 4'd0;
  assign out_new = outstanding_q + OW'(wr) - OW'(n);
  assign oseq_new = oseq_q + n;
  assign nak_now = ack_valid && ack_nak;
  assign restart = restart_q || nak_now;
  assign rdif = rseq_q + 1'b1 - oseq_new;
  assign nxt = (restart || rdif[SEQ_W-1]) ? oseq_new : rseq_q + 1'b1;
  assign ndif = nxt - oseq_new;
  assign done = ndif >= SEQ_W'(out_new);
  assign fdat = din[grant_q];
  assign frame = {next_seq_q, grant_q, fdat, ^{next_seq_q, grant_q, fdat}};
  assign {pop3, pop2, pop1, pop0} = pop_q;
  assign tx_valid = tx_valid_q;
  assign tx_data = tx_data_q;
  assign state = state_q;
  assign replay_full = outstanding_q == OW'(REPLAY_DEPTH);
  always_comb begin
    state_d = state_q;
    pop_d = 4'd0;
    tx_valid_d = tx_valid_q;
    tx_data_d = tx_data_q;
    next_seq_d = next_seq_q;
    rseq_d = rseq_q;
    rr_d = rr_q;
    grant_d = grant_q;
    restart_d = restart_q;
    outstanding_d = out_new;
    oseq_d = oseq_new;
    nak_pending_d = (nak_pending_q || nak_now) && out_new != '0;
    case (state_q)
      IDLE:
        if (nak_pending_q) begin
          if (out_new != '0) begin
            state_d = REPLAY;
            tx_valid_d = 1'b1;
            tx_data_d = rbuf_q[oseq_new[AW-1:0]];
            rseq_d = oseq_new;
            restart_d = 1'b0;
          end
        end else if (!replay_full && empty_v != 4'hf) begin
          pop_d = 4'd1 << gnt;
          rr_d = gnt;
          grant_d = gnt;
          state_d = FETCH;
        end
      FETCH:
        if (wr) begin
          tx_valid_d = 1'b1;
          tx_data_d = frame;
          state_d = SEND;
        end
      SEND:
        if (hs) begin
          tx_valid_d = 1'b0;
          next_seq_d = next_seq_q + 1'b1;
          state_d = IDLE;
        end
      default: begin
        restart_d = restart;
        if (hs) begin
          restart_d = 1'b0;
          tx_valid_d = !done;
          tx_data_d = done ? tx_data_q : rbuf_q[nxt[AW-1:0]];
          rseq_d = nxt;
          state_d = done ? IDLE : REPLAY;
          nak_pending_d = done ? 1'b0 : nak_pending_d;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pop_q <= 4'd0;
      tx_valid_q <= 1'b0;
      tx_data_q <= '0;
      next_seq_q <= '0;
      oseq_q <= '0;
      rseq_q <= '0;
      outstanding_q <= '0;
      rr_q <= 2'd3;
      grant_q <= 2'd0;
      nak_pending_q <= 1'b0;
      restart_q <= 1'b0;
      rbuf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      pop_q <= pop_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q <= tx_data_d;
      next_seq_q <= next_seq_d;
      oseq_q <= oseq_d;
      rseq_q <= rseq_d;
      outstanding_q <= outstanding_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      nak_pending_q <= nak_pending_d;
      restart_q <= restart_d;
      if (wr) rbuf_q[next_seq_q[AW-1:0]] <= frame;
    end
  end
endmodule

// File: tb/tb_data_link_tx.sv
// tb_data_link_tx: scoreboard bench for data_link_tx with FIFO model and ACK/NAK directed vectors
module tb_data_link_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] emp, pops;
  logic [9:0] din [4];
  logic tx_valid, replay_full;
  logic tx_ready = 1'b1;
  logic [20:0] tx_data;
  logic ack_valid = 1'b0, ack_nak = 1'b0;
  logic [7:0] ack_seq = 8'd0;
  logic [1:0] state;
  logic [9:0] mem [4][512];
  int push_idx [4] = '{0, 0, 0, 0};
  int pop_idx [4] = '{0, 0, 0, 0};
  logic [20:0] exp_q [$];
  int checks = 0, errors = 0, nsent = 0, cyc = 0;
  assign emp[0] = push_idx[0] == pop_idx[0];
  assign emp[1] = push_idx[1] == pop_idx[1];
  assign emp[2] = push_idx[2] == pop_idx[2];
  assign emp[3] = push_idx[3] == pop_idx[3];
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (pops[i] && pop_idx[i] != push_idx[i]) begin
        din[i] <= mem[i][pop_idx[i]];
        pop_idx[i] <= pop_idx[i] + 1;
      end
  data_link_tx dut (
    .clk(clk), .reset(reset),
    .empty0(emp[0]), .empty1(emp[1]), .empty2(emp[2]), .empty3(emp[3]),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .pop0(pops[0]), .pop1(pops[1]), .pop2(pops[2]), .pop3(pops[3]),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .ack_valid(ack_valid), .ack_nak(ack_nak), .ack_seq(ack_seq),
    .replay_full(replay_full), .state(state)
  );
  function automatic logic [20:0] fr(logic [7:0] s, logic [1:0] c, logic [9:0] d);
    return {s, c, d, ^{s, c, d}};
  endfunction
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(int ch, logic [9:0] d);
    mem[ch][push_idx[ch]] = d;
    push_idx[ch]++;
  endtask
  task automatic ld(int ch, logic [9:0] d, logic [7:0] s);
    exp_q.push_back(fr(s, 2'(ch), d));
    load(ch, d);
  endtask
  task automatic ack(logic nk, logic [7:0] s);
    ack_valid = 1'b1;
    ack_nak = nk;
    ack_seq = s;
    tick;
    ack_valid = 1'b0;
    ack_nak = 1'b0;
  endtask
  task automatic wait_sent(int n);
    int k = 0;
    while (nsent < n && k < 200) begin
      tick;
      k++;
    end
    chk("sent_count", nsent, n);
  endtask
  task automatic rst;
    chk("drained", exp_q.size(), 0);
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    nsent = 0;
  endtask
  task automatic monitor;
    logic pv = 1'b0, pp = 1'b0;
    int pc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
        pp = 1'b0;
      end else begin
        cyc++;
        if (|pops) begin
          chk("pop_onehot", 32'($onehot(pops)), 1);
          chk("pop_state", state, 1);
          chk("pop_gap", pp, 0);
          pc = cyc;
        end
        if (tx_valid && !pv && state == 2'd2) chk("latency", cyc - pc, 2);
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame act=%0h exp=none", tx_data);
          end else chk("frame", tx_data, exp_q.pop_front());
          nsent++;
        end
        pp = |pops;
        pv = tx_valid;
      end
    end
  endtask
  initial begin
    int k;
    fork monitor(); join_none
    tick;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_state", state, 0);
    chk("rst_pops", pops, 0);
    chk("rst_full", replay_full, 0);
    tick;
    reset = 1'b0;
    load(2, 10'h155);
    exp_q.push_back(21'h012AA);
    wait_sent(1);
    ack(1'b0, 8'h00);
    ld(2, 10'h0AB, 8'h01);
    wait_sent(2);
    ack(1'b0, 8'h01);
    rst;
    ld(0, 10'h011, 8'd0);
    ld(1, 10'h122, 8'd1);
    ld(2, 10'h233, 8'd2);
    ld(3, 10'h344, 8'd3);
    ld(0, 10'h3FF, 8'd4);
    for (int i = 0; i < 5; i++) begin
      wait_sent(i + 1);
      ack(1'b0, 8'(i));
    end
    rst;
    for (int i = 0; i < 6; i++) ld(1, 10'(i * 37 + 5), 8'(i));
    wait_sent(4);
    tick;
    chk("full_set", replay_full, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("full_no_pop", pops, 0);
    end
    ack(1'b0, 8'd1);
    chk("full_clear", replay_full, 0);
    wait_sent(6);
    chk("full_again", replay_full, 1);
    ack(1'b0, 8'd5);
    rst;
    ld(0, 10'h0A1, 8'd0);
    ld(0, 10'h1B2, 8'd1);
    ld(0, 10'h2C3, 8'd2);
    wait_sent(3);
    exp_q.push_back(fr(8'd1, 2'd0, 10'h1B2));
    exp_q.push_back(fr(8'd2, 2'd0, 10'h2C3));
    ack(1'b1, 8'd0);
    ld(3, 10'h3D4, 8'd3);
    wait_sent(6);
    ack(1'b0, 8'd3);
    rst;
    tx_ready = 1'b0;
    load(1, 10'h2AA);
    k = 0;
    while (!tx_valid && k < 20) begin
      tick;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      ack_valid = i == 2;
      ack_seq = 8'h05;
      tick;
      chk("hold_valid", tx_valid, 1);
      chk("hold_data", tx_data, 21'h00D54);
    end
    ack_valid = 1'b0;
    exp_q.push_back(21'h00D54);
    for (int i = 1; i < 4; i++) ld(1, 10'(i * 91), 8'(i));
    tx_ready = 1'b1;
    wait_sent(4);
    chk("stale_ack_full", replay_full, 1);
    ack(1'b0, 8'd3);
    rst;
    for (int i = 0; i < 255; i++) ld(0, 10'(i * 7 + 3), 8'(i));
    for (int i = 0; i < 255; i++) begin
      wait_sent(i + 1);
      ack(1'b0, 8'(i));
    end
    ld(2, 10'h1C3, 8'hFF);
    ld(2, 10'h03C, 8'h00);
    wait_sent(257);
    ack(1'b0, 8'h00);
    for (int i = 1; i < 5; i++) ld(1, 10'(i * 13), 8'(i));
    wait_sent(261);
    chk("wrap_full", replay_full, 1);
    ack(1'b0, 8'd4);
    load(3, 10'h155);
    k = 0;
    while (!(state == 2'd1 && pops == 4'd0) && k < 20) begin
      tick;
      k++;
    end
    chk("fetch_reached", state, 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_state", state, 0);
    chk("arst_pops", pops, 0);
    chk("arst_full", replay_full, 0);
    tick;
    tick;
    reset = 1'b0;
    nsent = 0;
    repeat (10) tick;
    chk("arst_nothing_sent", nsent, 0);
    chk("arst_idle", state, 0);
    chk("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
